// File: rtl/vga_fb_arbiter_if.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter_if
// Bundles the text-writer handshake and the character-RAM bus of the
// frame-buffer arbiter.
//
//   wr_req / wr_addr / wr_data   writer request, held stable until wr_ack
//   wr_ack / wr_err              one-cycle completion pulse (+ range error)
//   ram_en / ram_we / ram_addr / ram_wdata   single-port RAM access
//   ram_rdata                    RAM read data, one cycle after the read
//
// Modports:
//   slave  : the arbiter (consumes requests, drives the RAM bus)
//   master : the environment (writer + RAM)
// ----------------------------------------------------------------------------
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) ();
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              wr_err;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  wr_req, wr_addr, wr_data, ram_rdata,
      output wr_ack, wr_err, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output wr_req, wr_addr, wr_data, ram_rdata,
      input  wr_ack, wr_err, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port character RAM between VGA scan-out fetch and a text
// writer / built-in clear-screen sequencer. Display fetch owns every cycle
// with h<640, v<480, h[2:0]==0; all other cycles are writer slots.
//
// Ports:
//   clk_25     pixel clock
//   reset      synchronous, active-high reset
//   h_count    horizontal count 0..799
//   v_count    vertical count 0..524
//   clr_req    start clear-screen (sampled in IDLE only)
//   clr_busy   high while the clear sequence runs
//   char_code  fetched character for the glyph stage
//   char_valid one-cycle pulse, high in the cycle char_code carries new data
//   bus        writer handshake + RAM bus (vga_fb_arbiter_if.slave)
//   stall_cnt  (only with FB_ARB_STALL_CNT_EN) saturating count of cycles in
//              which wr_req was high but not serviced
//
// Optional feature macro: FB_ARB_STALL_CNT_EN
//
// Fetch timing: address driven in slot cycle t, RAM data returns in t+1 and
// is registered at the end of t+1, so char_code and char_valid both change
// together at the start of t+2.
// ----------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int                COLS       = 80,
   parameter int                ROWS       = 30,
   parameter int                ADDR_W     = 12,
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] CLEAR_CHAR = 8'h20
) (
   input  logic              clk_25,
   input  logic              reset,
   input  logic [15:0]       h_count,
   input  logic [15:0]       v_count,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic [DATA_W-1:0] char_code,
   output logic              char_valid,
`ifdef FB_ARB_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   vga_fb_arbiter_if.slave   bus
);

   localparam int                TILES     = COLS * ROWS;
   localparam logic [ADDR_W:0]   TILES_W   = (ADDR_W+1)'(TILES);
   localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(TILES - 1);
   localparam logic [15:0]       H_ACTIVE  = 16'(COLS * 8);
   localparam logic [15:0]       V_ACTIVE  = 16'(ROWS * 16);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACK   = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   logic [1:0]        state_reg;
   logic [ADDR_W-1:0] clr_ptr_reg;
   logic              clr_busy_reg;
   logic              wr_ack_reg;
   logic              wr_err_reg;
   logic              fetch_pend_reg;
   logic              char_valid_reg;
   logic [DATA_W-1:0] char_code_reg;

   logic              display_slot;
   logic              wr_in_range;
   logic              writer_service;
   logic              clear_write;
   logic [ADDR_W-1:0] tile_row;
   logic [ADDR_W-1:0] tile_col;
   logic [ADDR_W-1:0] fetch_addr;

   assign display_slot = (h_count < H_ACTIVE) && (v_count < V_ACTIVE) &&
                         (h_count[2:0] == 3'd0);

   assign tile_row = v_count[ADDR_W+3:4];
   assign tile_col = h_count[ADDR_W+2:3];

   // Row * COLS: the standard 80-column mode uses two shifts (64 + 16).
   generate
      if (COLS == 80) begin : g_mul80
         assign fetch_addr = (tile_row << 6) + (tile_row << 4) + tile_col;
      end else begin : g_mul
         assign fetch_addr = tile_row * ADDR_W'(COLS) + tile_col;
      end
   endgenerate

   assign wr_in_range = ({1'b0, bus.wr_addr} < TILES_W);

   // clr_req beats a simultaneous wr_req; a request is only consumed in
   // IDLE during a writer slot (out-of-range requests are acked without
   // touching the RAM).
   assign writer_service = (state_reg == ST_IDLE) && !clr_req &&
                           !display_slot && bus.wr_req;
   assign clear_write    = (state_reg == ST_CLEAR) && !display_slot;

   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (!reset) begin
         if (display_slot) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = fetch_addr;
         end else if (clear_write) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = clr_ptr_reg;
            bus.ram_wdata = CLEAR_CHAR;
         end else if (writer_service && wr_in_range) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = bus.wr_addr;
            bus.ram_wdata = bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk_25) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         clr_ptr_reg    <= '0;
         clr_busy_reg   <= 1'b0;
         wr_ack_reg     <= 1'b0;
         wr_err_reg     <= 1'b0;
         fetch_pend_reg <= 1'b0;
         char_valid_reg <= 1'b0;
         char_code_reg  <= '0;
      end else begin
         fetch_pend_reg <= display_slot;
         char_valid_reg <= fetch_pend_reg;
         if (fetch_pend_reg) begin
            char_code_reg <= bus.ram_rdata;
         end
         wr_ack_reg <= writer_service;
         wr_err_reg <= writer_service && !wr_in_range;

         case (state_reg)
            ST_IDLE: begin
               if (clr_req) begin
                  state_reg    <= ST_CLEAR;
                  clr_ptr_reg  <= '0;
                  clr_busy_reg <= 1'b1;
               end else if (writer_service) begin
                  state_reg <= ST_ACK;
               end
            end
            ST_ACK: begin
               state_reg <= ST_IDLE;
            end
            ST_CLEAR: begin
               if (clear_write) begin
                  if (clr_ptr_reg == LAST_TILE) begin
                     state_reg    <= ST_IDLE;
                     clr_ptr_reg  <= '0;
                     clr_busy_reg <= 1'b0;
                  end else begin
                     clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FB_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   always_ff @(posedge clk_25) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (bus.wr_req && !writer_service && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

   assign bus.wr_ack = wr_ack_reg;
   assign bus.wr_err = wr_err_reg;
   assign clr_busy   = clr_busy_reg;
   assign char_code  = char_code_reg;
   assign char_valid = char_valid_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Drives h/v counts, writer requests and clear requests into vga_fb_arbiter,
// emulates the character RAM, and compares every cycle against a behavioural
// model built from the slot / handshake rules. Directed scenarios pin a few
// literal values (fetch address 162 -> 8'hA2, 80 pulses per active line,
// 38400 per frame, 2400 ordered clear writes).
// ----------------------------------------------------------------------------
module tb_vga_fb_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int TILES  = 2400;

   logic        clk_25 = 1'b0;
   logic        reset;
   logic [15:0] h_count;
   logic [15:0] v_count;
   logic        clr_req;
   logic        clr_busy;
   logic [7:0]  char_code;
   logic        char_valid;
`ifdef FB_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   always #5 clk_25 = ~clk_25;

   vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vga_fb_arbiter #(
      .COLS(80), .ROWS(30), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_CHAR(8'h20)
   ) dut (
      .clk_25     (clk_25),
      .reset      (reset),
      .h_count    (h_count),
      .v_count    (v_count),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .char_code  (char_code),
      .char_valid (char_valid),
`ifdef FB_ARB_STALL_CNT_EN
      .stall_cnt  (stall_cnt),
`endif
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- character RAM emulation (environment) ----------------
   logic [7:0] ram_mem [0:4095];
   bit         mem_init_done = 1'b0;

   always @(posedge clk_25) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 4096; i++) ram_mem[i] = i[7:0];
         mem_init_done = 1'b1;
      end else if (bus.ram_en) begin
         if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata <= ram_mem[bus.ram_addr];
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   logic [7:0] shadow [0:4096-1];
   bit   m_known = 1'b0;
   bit   m_clearing, m_ack, m_err, m_valid, p_valid;
   int   m_clr_next;
   logic [7:0] m_code, p_code;
   int   m_stall;

   initial begin
      int  h, v, faddr, e_addr;
      bit  slot, in_rng, serve, e_en, e_we;
      logic [7:0] e_wd;
      for (int i = 0; i < 4096; i++) shadow[i] = i[7:0];
      forever begin
         @(negedge clk_25);
         h      = int'(h_count);
         v      = int'(v_count);
         slot   = (h < 640) && (v < 480) && (h % 8 == 0);
         faddr  = (v / 16) * 80 + h / 8;
         in_rng = int'(bus.wr_addr) < TILES;
         serve  = !reset && m_known && !slot && !m_clearing && !m_ack &&
                  !clr_req && bus.wr_req;
         e_en = 1'b0; e_we = 1'b0; e_addr = 0; e_wd = 8'h00;
         if (!reset) begin
            if (slot) begin
               e_en = 1'b1; e_addr = faddr;
            end else if (m_known && m_clearing) begin
               e_en = 1'b1; e_we = 1'b1; e_addr = m_clr_next; e_wd = 8'h20;
            end else if (serve && in_rng) begin
               e_en = 1'b1; e_we = 1'b1; e_addr = int'(bus.wr_addr); e_wd = bus.wr_data;
            end
         end
         if (reset || m_known) begin
            chk("ram_en", bus.ram_en, e_en);
            chk("ram_we", bus.ram_we, e_we);
            if (e_en) chk("ram_addr", bus.ram_addr, e_addr);
            if (e_we) chk("ram_wdata", bus.ram_wdata, e_wd);
         end
         if (m_known) begin
            chk("char_valid", char_valid, m_valid);
            chk("char_code", char_code, m_code);
            chk("wr_ack", bus.wr_ack, m_ack);
            chk("wr_err", bus.wr_err, m_err);
            chk("clr_busy", clr_busy, m_clearing);
`ifdef FB_ARB_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
         end
         if (char_valid === 1'b1) pulse_cnt++;

         // advance the model to the next cycle
         if (reset) begin
            m_known = 1'b1; m_clearing = 1'b0; m_clr_next = 0; m_ack = 1'b0;
            m_err = 1'b0; m_valid = 1'b0; p_valid = 1'b0; m_code = 8'h00;
            p_code = 8'h00; m_stall = 0;
         end else if (m_known) begin
            m_valid = p_valid;
            if (p_valid) m_code = p_code;
            p_valid = slot;
            if (slot) p_code = shadow[faddr];
            if (e_we) shadow[e_addr] = e_wd;
            if (bus.wr_req && !serve && m_stall < 65535) m_stall++;
            if (m_clearing) begin
               if (!slot) begin
                  m_clr_next++;
                  if (m_clr_next == TILES) begin
                     m_clearing = 1'b0; m_clr_next = 0;
                  end
               end
            end else if (!m_ack && clr_req) begin
               m_clearing = 1'b1; m_clr_next = 0;
            end
            m_err = serve && !in_rng;
            m_ack = serve;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int h, input int v);
      @(posedge clk_25);
      #1;
      h_count = 16'(h);
      v_count = 16'(v);
   endtask

   initial begin
      int clr_cnt, order_err, ack_in_clear, stray;
      bit done, got;
      reset = 1'b1; h_count = 16'd0; v_count = 16'd0; clr_req = 1'b0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

      // reset: fetch slot inputs must not reach the RAM while reset is high
      cyc(0, 0); cyc(0, 0);
      #2 chk("rst_ram_en", bus.ram_en, 1'b0);
      cyc(700, 0); reset = 1'b0;
      #2;
      chk("rst_clr_busy", clr_busy, 1'b0);
      chk("rst_wr_ack", bus.wr_ack, 1'b0);
      chk("rst_char_valid", char_valid, 1'b0);
      chk("rst_char_code", char_code, 8'h00);

      // one active line and one blank line, full horizontal sweep
      pulse_cnt = 0;
      for (int h = 0; h < 800; h++) cyc(h, 0);
      repeat (3) cyc(700, 490);
      @(negedge clk_25); #1;
      chk("line_pulses", pulse_cnt, 80);
      pulse_cnt = 0;
      for (int h = 0; h < 800; h++) cyc(h, 524);
      repeat (3) cyc(700, 490);
      @(negedge clk_25); #1;
      chk("blank_line_pulses", pulse_cnt, 0);

      // every display slot of a frame
      pulse_cnt = 0;
      for (int v = 0; v < 480; v++) begin
         for (int c = 0; c < 80; c++) begin
            cyc(c * 8, v);
            if (v == 32 && c == 2) begin
               #2 chk("fetch_addr_h16_v32", bus.ram_addr, 162);
            end
            if (v == 32 && c == 4) begin
               #2 chk("char_code_h16_v32", char_code, 8'hA2);
            end
         end
      end
      repeat (3) cyc(700, 490);
      @(negedge clk_25); #1;
      chk("frame_pulses", pulse_cnt, 38400);

      // in-range write in blanking
      cyc(700, 100);
      bus.wr_req = 1'b1; bus.wr_addr = 12'd5; bus.wr_data = 8'h41;
      #2;
      chk("wr5_we", bus.ram_we, 1'b1);
      chk("wr5_addr", bus.ram_addr, 12'd5);
      chk("wr5_data", bus.ram_wdata, 8'h41);
      cyc(701, 100); bus.wr_req = 1'b0;
      #2;
      chk("wr5_ack", bus.wr_ack, 1'b1);
      chk("wr5_err", bus.wr_err, 1'b0);
      cyc(702, 100);

      // request landing on a display slot waits one cycle
      cyc(8, 0);
      bus.wr_req = 1'b1; bus.wr_addr = 12'd7; bus.wr_data = 8'h55;
      #2 chk("slot_no_write", bus.ram_we, 1'b0);
      cyc(9, 0);
      #2;
      chk("h9_we", bus.ram_we, 1'b1);
      chk("h9_addr", bus.ram_addr, 12'd7);
      cyc(10, 0); bus.wr_req = 1'b0;
      #2 chk("h10_ack", bus.wr_ack, 1'b1);

      // out-of-range address
      cyc(700, 200);
      bus.wr_req = 1'b1; bus.wr_addr = 12'd2400; bus.wr_data = 8'h99;
      #2 chk("oor_no_we", bus.ram_we, 1'b0);
      cyc(701, 200); bus.wr_req = 1'b0;
      #2;
      chk("oor_ack", bus.wr_ack, 1'b1);
      chk("oor_err", bus.wr_err, 1'b1);

      // reset after 100 clear writes
      cyc(700, 490); clr_req = 1'b1;
      for (int k = 0; k < 100; k++) begin
         cyc(700, 490); clr_req = 1'b0;
         if (k == 99) begin
            #2 chk("clr_write_99", bus.ram_addr, 12'd99);
         end
      end
      cyc(700, 490); reset = 1'b1;
      #2 chk("rst_mid_clear_en", bus.ram_en, 1'b0);
      cyc(700, 490); reset = 1'b0;
      #2 chk("rst_mid_clear_busy", clr_busy, 1'b0);
      stray = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(700, 490);
         #2 if (bus.ram_we) stray++;
      end
      chk("no_writes_after_abort", stray, 0);
      chk("mem99_cleared", ram_mem[99], 8'h20);
      chk("mem100_untouched", ram_mem[100], 8'h64);

      // full clear with a writer waiting behind it
      cyc(700, 490); clr_req = 1'b1;
      #2 chk("clr_req_no_write", bus.ram_we, 1'b0);
      clr_cnt = 0; order_err = 0; ack_in_clear = 0; done = 1'b0;
      for (int k = 0; k < 5000 && !done; k++) begin
         cyc(k % 800, 0);
         clr_req = 1'b0;
         bus.wr_req = 1'b1; bus.wr_addr = 12'd0; bus.wr_data = 8'h5A;
         #2;
         if (!clr_busy) begin
            done = 1'b1;
         end else begin
            if (bus.wr_ack) ack_in_clear++;
            if (bus.ram_we) begin
               if (int'(bus.ram_addr) != clr_cnt || bus.ram_wdata != 8'h20) order_err++;
               clr_cnt++;
            end
         end
      end
      chk("clear_finished", done, 1'b1);
      chk("clear_write_count", clr_cnt, 2400);
      chk("clear_order", order_err, 0);
      chk("no_ack_during_clear", ack_in_clear, 0);
      got = 1'b0;
      for (int j = 0; j < 4 && !got; j++) begin
         cyc(700, 490);
         #2 if (bus.wr_ack) got = 1'b1;
      end
      bus.wr_req = 1'b0;
      chk("writer_after_clear", got, 1'b1);
      chk("mem0_writer", ram_mem[0], 8'h5A);
      chk("mem2399_cleared", ram_mem[2399], 8'h20);

      // randomized traffic
      for (int n = 0; n < 15000; n++) begin
         if ($urandom_range(0, 3) == 0) cyc($urandom_range(640, 799), $urandom_range(0, 524));
         else                           cyc($urandom_range(0, 799), $urandom_range(0, 524));
         reset   = ($urandom_range(0, 1999) == 0);
         clr_req = ($urandom_range(0, 2999) == 0);
         if (bus.wr_ack || !bus.wr_req) begin
            if ($urandom_range(0, 2) != 0) begin
               bus.wr_req  = 1'b1;
               bus.wr_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(2400, 4095))
                                                         : 12'($urandom_range(0, 2399));
               bus.wr_data = 8'($urandom);
            end else begin
               bus.wr_req = 1'b0;
            end
         end
      end
      reset = 1'b0; clr_req = 1'b0; bus.wr_req = 1'b0;
      repeat (4) cyc(700, 490);
      @(negedge clk_25); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
